// File: rtl/branch_resolver.sv
// branch_resolver: execute-stage checker for fetch-stage branch predictions.
// Keeps an in-order queue of predictions and compares each one with the
// resolved outcome from the ALU. On a mispredict it raises a flush, supplies
// the corrected fetch PC, and clears the queue. Every resolve also emits a
// one-cycle training packet for the predictor tables.
// Optional feature: define BRANCH_RESOLVER_STATS_EN to build the saturating
// resolve/mispredict counters; otherwise both count ports are tied to zero.
module branch_resolver #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int QUEUE_DEPTH   = 4,
  parameter int FLUSH_CYCLES  = 2
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_IF_valid,
  input  logic [ADDRESS_WIDTH-1:0] i_IF_pc,
  input  logic                     i_IF_taken,
  input  logic [ADDRESS_WIDTH-1:0] i_IF_target,
  input  logic                     i_EX_valid,
  input  logic                     i_EX_outcome,
  input  logic [ADDRESS_WIDTH-1:0] i_EX_target,
  output logic                     o_full,
  output logic                     o_flush,
  output logic                     o_redirect_valid,
  output logic [ADDRESS_WIDTH-1:0] o_redirect_pc,
  output logic                     o_update_valid,
  output logic [ADDRESS_WIDTH-1:0] o_update_pc,
  output logic                     o_update_taken,
  output logic                     o_update_mispredict,
  output logic                     o_error,
  output logic [15:0]              o_branch_count,
  output logic [15:0]              o_mispredict_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         flush_cnt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]           head;
  logic [PTR_W:0]           tail;
  logic [PTR_W-1:0]         head_idx;
  logic [PTR_W-1:0]         tail_idx;

  logic [ADDRESS_WIDTH-1:0] pc_mem     [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0] target_mem [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]   taken_mem;

  logic                     empty;
  logic                     full;
  logic                     do_resolve;
  logic                     do_enq;
  logic                     enq_drop;
  logic                     bad_resolve;
  logic                     mispredict;
  logic [ADDRESS_WIDTH-1:0] head_pc;
  logic                     head_taken;
  logic [ADDRESS_WIDTH-1:0] head_target;
  logic [ADDRESS_WIDTH-1:0] redirect_next;

  assign head_idx = head[PTR_W-1:0];
  assign tail_idx = tail[PTR_W-1:0];
  assign o_full   = full;

  // Queue status, head entry decode and resolve/enqueue qualification.
  always_comb begin
    empty       = (head == tail);
    full        = (head[PTR_W] != tail[PTR_W]) && (head_idx == tail_idx);
    head_pc     = pc_mem[head_idx];
    head_taken  = taken_mem[head_idx];
    head_target = target_mem[head_idx];
    do_resolve  = (state == RUN) && i_EX_valid && !empty;
    // A full queue can still accept when the head pops on the same edge.
    do_enq      = (state == RUN) && i_IF_valid && (!full || do_resolve);
    enq_drop    = (state == RUN) && i_IF_valid && full && !do_resolve;
    bad_resolve = (state == RUN) && i_EX_valid && empty;
    mispredict  = (head_taken != i_EX_outcome) ||
                  (head_taken && i_EX_outcome && (head_target != i_EX_target));
    redirect_next = i_EX_outcome ? i_EX_target
                                 : head_pc + ADDRESS_WIDTH'(1);
  end

  // Prediction storage; written at the tail on every accepted enqueue.
  always_ff @(posedge i_Clk) begin
    if (do_enq) begin
      pc_mem[tail_idx]     <= i_IF_pc;
      target_mem[tail_idx] <= i_IF_target;
      taken_mem[tail_idx]  <= i_IF_taken;
    end
  end

  // Control FSM: pointers, flush sequencing, training packet and redirect.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state               <= RUN;
      flush_cnt           <= '0;
      head                <= '0;
      tail                <= '0;
      o_flush             <= 1'b0;
      o_redirect_valid    <= 1'b0;
      o_redirect_pc       <= '0;
      o_update_valid      <= 1'b0;
      o_update_pc         <= '0;
      o_update_taken      <= 1'b0;
      o_update_mispredict <= 1'b0;
      o_error             <= 1'b0;
    end else begin
      o_update_valid   <= 1'b0;
      o_redirect_valid <= 1'b0;
      if (enq_drop || bad_resolve) begin
        o_error <= 1'b1;
      end
      case (state)
        RUN: begin
          if (do_resolve) begin
            o_update_valid      <= 1'b1;
            o_update_pc         <= head_pc;
            o_update_taken      <= i_EX_outcome;
            o_update_mispredict <= mispredict;
          end
          if (do_resolve && mispredict) begin
            // Emptying via head <= tail also discards a same-edge enqueue,
            // since tail is left at its pre-enqueue value.
            head             <= tail;
            state            <= FLUSH;
            flush_cnt        <= CNT_W'(FLUSH_CYCLES);
            o_flush          <= 1'b1;
            o_redirect_valid <= 1'b1;
            o_redirect_pc    <= redirect_next;
          end else begin
            if (do_resolve) begin
              head <= head + (PTR_W + 1)'(1);
            end
            if (do_enq) begin
              tail <= tail + (PTR_W + 1)'(1);
            end
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt - CNT_W'(1);
          o_flush   <= (flush_cnt > CNT_W'(1));
          if (flush_cnt == CNT_W'(1)) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  // Saturating resolve and mispredict statistics.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_branch_count     <= '0;
      o_mispredict_count <= '0;
    end else begin
      if (do_resolve && (o_branch_count != '1)) begin
        o_branch_count <= o_branch_count + 16'd1;
      end
      if (do_resolve && mispredict && (o_mispredict_count != '1)) begin
        o_mispredict_count <= o_mispredict_count + 16'd1;
      end
    end
  end
`else
  assign o_branch_count     = '0;
  assign o_mispredict_count = '0;
`endif

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage counterpart of the fetch-stage branch predictor. Records every prediction issued at fetch in a small in-order queue, checks each against the real outcome when the branch resolves in the ALU stage, and produces the pipeline flush, the corrected fetch PC, and a one-cycle training packet back to the predictor tables. Sits between the IF-stage predictor, the ALU stage and the PC-select logic.

## Interface
- ADDRESS_WIDTH, 22, width of instruction word addresses
- QUEUE_DEPTH, 4, in-flight prediction entries (power of two, ≥2)
- FLUSH_CYCLES, 2, cycles fetch is squashed after a mispredict (≥1)

- i_Clk  in  1  clock, rising edge
- i_Reset_n  in  1  asynchronous active-low reset
- i_IF_valid  in  1  fetch issued a prediction for a branch this cycle
- i_IF_pc  in  ADDRESS_WIDTH  PC of that branch
- i_IF_taken  in  1  predicted direction
- i_IF_target  in  ADDRESS_WIDTH  predicted target (ignored if not taken)
- i_EX_valid  in  1  oldest outstanding branch resolved this cycle
- i_EX_outcome  in  1  actual direction (1 = taken)
- i_EX_target  in  ADDRESS_WIDTH  computed target
- o_full  out  1  queue full; fetch must hold branches
- o_flush  out  1  squash younger instructions
- o_redirect_valid  out  1  load o_redirect_pc into PC
- o_redirect_pc  out  ADDRESS_WIDTH  corrected fetch address
- o_update_valid  out  1  training packet valid
- o_update_pc  out  ADDRESS_WIDTH  PC of resolved branch
- o_update_taken  out  1  actual direction
- o_update_mispredict  out  1  prediction was wrong
- o_error  out  1  sticky: resolve with empty queue or enqueue when full
- o_branch_count  out  16  resolved branches (stats)
- o_mispredict_count  out  16  mispredicts (stats)

## Operation
- Queue: circular FIFO, head/tail pointers with one extra wrap bit; entry = {pc, taken, target}. o_full combinational from pointers.
- Enqueue when i_IF_valid and state RUN and not full (or full with simultaneous dequeue). Enqueue while full without dequeue: dropped, o_error set.
- Resolve when i_EX_valid and queue non-empty: pop head. Mispredict = (taken ≠ i_EX_outcome) or (both taken and target ≠ i_EX_target).
- Redirect PC: i_EX_target if i_EX_outcome, else head.pc + 1 (word address, wraps mod 2^ADDRESS_WIDTH).
- Training packet emitted for every resolve, mispredict or not.
- i_EX_valid with empty queue: no pop, no update, no flush, o_error set.
- States: RUN, FLUSH. RUN→FLUSH on mispredict: queue cleared (head = tail, younger predictions discarded, including any same-cycle enqueue), flush counter loaded with FLUSH_CYCLES. In FLUSH, i_IF_valid and i_EX_valid ignored; counter decrements each cycle; FLUSH→RUN when counter reaches 1→0.
- o_error clears only on reset.

## Timing
- All outputs except o_full registered; one-cycle latency from the resolving edge.
- o_update_* and o_redirect_valid: single-cycle pulses.
- o_flush high for FLUSH_CYCLES consecutive cycles starting the cycle after the mispredicting resolve; o_redirect_valid only in the first.
- Simultaneous enqueue and resolve in RUN: both take effect same edge; if resolve mispredicts, the enqueue is discarded.
- Reset (any time, including mid-FLUSH): state RUN, queue empty, all outputs 0, counters 0.

## Configuration
- BRANCH_RESOLVER_STATS_EN defined: o_branch_count increments per resolve, o_mispredict_count per mispredict, both saturate at 16'hFFFF.
- Undefined: counter registers not built; both ports driven constant 0. All other behaviour identical.

## Test plan
- Enqueue pc=0x10 taken target=0x40; resolve outcome=1 target=0x40 -> next cycle o_update_valid=1, pc=0x10, taken=1, mispredict=0; o_flush=0.
- Enqueue pc=0x20 not taken; resolve outcome=1 target=0x80 -> o_flush=1 for 2 cycles, o_redirect_valid=1 with o_redirect_pc=0x80 in first; queue empty afterwards.
- Enqueue pc=0x30 taken target=0x50; resolve outcome=0 -> o_redirect_pc=0x31, o_update_mispredict=1; pc=0x3FFFFF same case -> redirect 0x000000.
- Enqueue 4 branches -> o_full=1; 5th enqueue with no resolve -> dropped, o_error=1; enqueue+resolve same cycle while full -> accepted, o_full stays 1.
- Three queued, first mispredicts while fourth enqueued same cycle -> queue empty, i_EX_valid during FLUSH ignored, o_update_valid=0 for it.
- With stats macro: 5 resolves, 2 mispredicts -> counts 5 and 2; assert reset mid-FLUSH -> all outputs 0, state RUN next cycle.
